// File: rtl/ten_gig_tx_frame_shaper_if.sv
// rtl/ten_gig_tx_frame_shaper_if.sv - 64-bit AXI-Stream bundle used on both sides of the frame shaper
interface ten_gig_tx_frame_shaper_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/ten_gig_tx_frame_shaper.sv
// rtl/ten_gig_tx_frame_shaper.sv - pads short frames, clips long frames and drops their tail ahead of a 10G MAC TX port
module ten_gig_tx_frame_shaper #(
    parameter int P_MIN_LENGTH = 60,
    parameter int P_MAX_LENGTH = 9600
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    ten_gig_tx_frame_shaper_if.slave           s_axis,
    ten_gig_tx_frame_shaper_if.master          m_axis,
    output logic [31:0]                        o_frame_cnt,
    output logic [31:0]                        o_pad_cnt,
    output logic [31:0]                        o_trunc_cnt
);
    typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_DROP} state_t;

    localparam logic [15:0] MIN_L = 16'(P_MIN_LENGTH);
    localparam logic [15:0] MAX_L = 16'(P_MAX_LENGTH);

    function automatic logic [7:0] lsb_ones(input logic [15:0] k);
        if (k >= 16'd8) return 8'hFF;
        return 8'((9'd1 << k[2:0]) - 9'd1);
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        rdy_en_q;
    logic        m_valid_q, m_valid_d;
    logic [63:0] m_data_q, m_data_d;
    logic [7:0]  m_keep_q, m_keep_d;
    logic        m_last_q, m_last_d;
    logic        m_user_q, m_user_d;
    logic        m_pad_q, m_pad_d;
    logic        m_trunc_q, m_trunc_d;
    logic [31:0] frame_cnt_q, pad_cnt_q, trunc_cnt_q;

    logic        out_free, s_ready, s_fire, beat_err, m_fire;
    logic [15:0] sum, cnt8;

    always_comb begin
        out_free = !m_valid_q || m_axis.tready;
        s_ready  = rdy_en_q && (((state_q == ST_DATA) && out_free) || (state_q == ST_DROP));
        s_fire   = s_axis.tvalid && s_ready;
        m_fire   = m_valid_q && m_axis.tready;
        sum      = {1'b0, cnt_q} + {12'd0, popcount(s_axis.tkeep)};
        cnt8     = {1'b0, cnt_q} + 16'd8;
        beat_err = err_q | s_axis.tuser;

        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m_valid_d = m_valid_q && !m_axis.tready;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        m_pad_d   = m_pad_q;
        m_trunc_d = m_trunc_q;

        case (state_q)
            ST_DATA: begin
                if (s_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis.tdata;
                    m_keep_d  = s_axis.tkeep;
                    m_last_d  = 1'b0;
                    m_user_d  = 1'b0;
                    m_pad_d   = 1'b0;
                    m_trunc_d = 1'b0;
                    // A non-last beat that reaches the limit guarantees the frame overruns it.
                    if ((sum > MAX_L) || (!s_axis.tlast && (sum >= MAX_L))) begin
                        m_keep_d  = lsb_ones(MAX_L - {1'b0, cnt_q});
                        m_last_d  = 1'b1;
                        m_user_d  = 1'b1;
                        m_trunc_d = 1'b1;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        if (!s_axis.tlast) state_d = ST_DROP;
                    end else if (!s_axis.tlast) begin
                        cnt_d = cnt_q + 15'd8;
                        err_d = beat_err;
                    end else if (sum >= MIN_L) begin
                        m_last_d = 1'b1;
                        m_user_d = beat_err;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                    end else begin
                        m_data_d = s_axis.tdata & byte_mask(s_axis.tkeep);
                        if (cnt8 >= MIN_L) begin
                            m_keep_d = lsb_ones(MIN_L - {1'b0, cnt_q});
                            m_last_d = 1'b1;
                            m_user_d = beat_err;
                            m_pad_d  = 1'b1;
                            cnt_d    = '0;
                            err_d    = 1'b0;
                        end else begin
                            m_keep_d = 8'hFF;
                            cnt_d    = cnt_q + 15'd8;
                            err_d    = beat_err;
                            state_d  = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_keep_d  = 8'hFF;
                    m_last_d  = 1'b0;
                    m_user_d  = 1'b0;
                    m_pad_d   = 1'b0;
                    m_trunc_d = 1'b0;
                    cnt_d     = cnt_q + 15'd8;
                    if (cnt8 >= MIN_L) begin
                        m_keep_d = lsb_ones(MIN_L - {1'b0, cnt_q});
                        m_last_d = 1'b1;
                        m_user_d = err_q;
                        m_pad_d  = 1'b1;
                        cnt_d    = '0;
                        err_d    = 1'b0;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DROP: begin
                if (s_fire && s_axis.tlast) state_d = ST_DATA;
            end
            default: state_d = ST_DATA;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_DATA;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            m_pad_q     <= 1'b0;
            m_trunc_q   <= 1'b0;
            frame_cnt_q <= '0;
            pad_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdy_en_q  <= 1'b1;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            m_pad_q   <= m_pad_d;
            m_trunc_q <= m_trunc_d;
            if (m_fire && m_last_q) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
                if (m_pad_q)   pad_cnt_q   <= pad_cnt_q + 32'd1;
                if (m_trunc_q) trunc_cnt_q <= trunc_cnt_q + 32'd1;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = m_user_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_pad_cnt     = pad_cnt_q;
    assign o_trunc_cnt   = trunc_cnt_q;
endmodule

// File: tb/tb_ten_gig_tx_frame_shaper.sv
// tb/tb_ten_gig_tx_frame_shaper.sv - directed scoreboard bench for the 10G TX frame shaper
module tb_ten_gig_tx_frame_shaper;
    localparam int MIN_L = 60;
    localparam int MAX_L = 9600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frame_cnt, pad_cnt, trunc_cnt;

    always #5 clk = ~clk;

    ten_gig_tx_frame_shaper_if s_if ();
    ten_gig_tx_frame_shaper_if m_if ();

    ten_gig_tx_frame_shaper #(.P_MIN_LENGTH(MIN_L), .P_MAX_LENGTH(MAX_L)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .o_frame_cnt (frame_cnt),
        .o_pad_cnt   (pad_cnt),
        .o_trunc_cnt (trunc_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0, exp_pads = 0, exp_truncs = 0;
    logic  rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] byte_val(input int idx, input int seed);
        return 8'(idx * 7 + seed);
    endfunction

    // Byte-level reference: the output frame is the input clamped to [MIN_L, MAX_L], zero filled.
    task automatic model_frame(input int len, input int seed, input bit err);
        int    out_len;
        int    nb;
        beat_t b;
        out_len = (len < MIN_L) ? MIN_L : ((len > MAX_L) ? MAX_L : len);
        nb      = (out_len + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            b.data = '0;
            b.keep = '0;
            b.mask = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*j + k < out_len) b.keep[k] = 1'b1;
                if (8*j + k < len) b.data[8*k +: 8] = byte_val(8*j + k, seed);
                if (len < MIN_L || (8*j + k < out_len)) b.mask[8*k +: 8] = 8'hFF;
            end
            b.last = (j == nb - 1);
            b.user = b.last && (err || len > MAX_L);
            exp_q.push_back(b);
        end
        exp_frames++;
        if (len < MIN_L) exp_pads++;
        if (len > MAX_L) exp_truncs++;
    endtask

    task automatic send_frame(input int len, input int seed, input int err_beat, input bit lat_chk);
        int          nb;
        int          t;
        logic [63:0] d;
        logic [7:0]  kp;
        model_frame(len, seed, err_beat >= 0);
        nb = (len + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 8; k++) begin
                kp[k]        = (8*j + k < len);
                d[8*k +: 8]  = kp[k] ? byte_val(8*j + k, seed) : 8'hA5;
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = d;
            s_if.tkeep  = kp;
            s_if.tlast  = (j == nb - 1);
            s_if.tuser  = (j == err_beat);
            t = 0;
            @(negedge clk);
            while (!s_if.tready && t < 2000) begin
                t++;
                @(negedge clk);
            end
            if (t >= 2000) chk("in_accept_timeout", 64'(t), 64'd0);
            @(posedge clk);
            #1;
            if (lat_chk && j == 0) begin
                chk("latency_valid", 64'(m_if.tvalid), 64'd1);
                chk("latency_data", m_if.tdata, d);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic drain_and_count();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        chk("pad_cnt", 64'(pad_cnt), 64'(exp_pads));
        chk("trunc_cnt", 64'(trunc_cnt), 64'(exp_truncs));
    endtask

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        beat_t       e;
        logic        stalled;
        logic [63:0] pd;
        logic [9:0]  pc;
        stalled = 1'b0;
        pd      = '0;
        pc      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 64'(m_if.tvalid), 64'd1);
                    chk("stall_data", m_if.tdata, pd);
                    chk("stall_ctl", 64'({m_if.tkeep, m_if.tlast, m_if.tuser}), 64'(pc));
                end
                stalled = m_if.tvalid && !m_if.tready;
                pd      = m_if.tdata;
                pc      = {m_if.tkeep, m_if.tlast, m_if.tuser};
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_if.tdata & e.mask, e.data & e.mask);
                        chk("beat_keep", 64'(m_if.tkeep), 64'(e.keep));
                        chk("beat_last", 64'(m_if.tlast), 64'(e.last));
                        chk("beat_user", 64'(m_if.tuser), 64'(e.user));
                    end
                end
            end
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lens[13];
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        lens = '{128, 20, 57, 65, 1, 300, 59, 60, 9608, 200, 9, 64, 100};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", m_if.tdata, 64'd0);
        chk("rst_m_ctl", 64'({m_if.tkeep, m_if.tlast, m_if.tuser}), 64'd0);
        chk("rst_counters", {frame_cnt, pad_cnt | trunc_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_before_edge", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        chk("tready_rise", 64'(s_if.tready), 64'd1);

        send_frame(128, 1, -1, 1'b1);
        drain_and_count();

        send_frame(20, 2, -1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("pad_tready_low", 64'(s_if.tready), 64'd0);
        end
        @(negedge clk);
        chk("pad_done_tready", 64'(s_if.tready), 64'd1);
        drain_and_count();

        send_frame(57, 3, -1, 1'b0);
        drain_and_count();

        send_frame(9608, 4, -1, 1'b0);
        drain_and_count();
        send_frame(9601, 5, -1, 1'b0);
        send_frame(9600, 6, -1, 1'b0);
        drain_and_count();

        send_frame(30, 7, 1, 1'b0);
        send_frame(64, 8, 0, 1'b0);
        send_frame(59, 9, -1, 1'b0);
        send_frame(60, 10, -1, 1'b0);
        send_frame(61, 11, -1, 1'b0);
        send_frame(8, 12, -1, 1'b0);
        send_frame(1, 13, -1, 1'b0);
        drain_and_count();

        rand_ready = 1'b1;
        for (int i = 0; i < 13; i++) send_frame(lens[i], 20 + i, (i % 4 == 1) ? 0 : -1, 1'b0);
        drain_and_count();
        rand_ready = 1'b0;

        send_frame(20, 40, -1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midpad_rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("midpad_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("midpad_rst_m_tdata", m_if.tdata, 64'd0);
        chk("midpad_rst_m_ctl", 64'({m_if.tkeep, m_if.tlast, m_if.tuser}), 64'd0);
        chk("midpad_rst_counters", {frame_cnt, pad_cnt | trunc_cnt}, 64'd0);
        exp_q.delete();
        exp_frames = 0;
        exp_pads   = 0;
        exp_truncs = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(64, 41, -1, 1'b0);
        drain_and_count();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
